// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the multiply/divide unit and the control unit that
// drives it: the two-bit operation encoding and the unit's state encoding.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package mult_div_pkg;

   // Operation codes as presented on the Op input of the unit.
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MTHI  = 2'b10,
      OP_MTLO  = 2'b11
   } op_e;

   // Sequencer states; MUL and DIV are the only busy states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // True for the iterative operations, which run for WIDTH cycles and own
   // the divide-by-zero flag.
   function automatic logic isLongOp(input op_e op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative unsigned multiply / restoring divide unit with HI/LO registers.
// MULTU and DIVU take WIDTH cycles each through one shared WIDTH+1-bit
// adder/subtractor; MTHI/MTLO write HI or LO directly at the accepting edge.
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   Start      request pulse, only looked at while not busy
//   Op         operation select (MULTU, DIVU, MTHI, MTLO)
//   OperandA   multiplicand, dividend or move data
//   OperandB   multiplier or divisor
//   Hi, Lo     architectural HI/LO registers
//   Busy       iteration in progress
//   Done       one-cycle completion pulse for MULTU/DIVU
//   DivByZero  last DIVU had a zero divisor
// ---------------------------------------------------------------------------
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

   state_e           state;
   state_e           nextState;
   op_e              opSel;
   logic             accept;
   logic             lastStep;
   logic [CntW-1:0]  count;
   logic [WIDTH-1:0] operandReg;
   logic [WIDTH-1:0] accHi;
   logic [WIDTH-1:0] accLo;
   logic [WIDTH:0]   addA;
   logic [WIDTH:0]   addB;
   logic             carryIn;
   logic [WIDTH+1:0] addSum;
   logic [WIDTH-1:0] nextHi;
   logic [WIDTH-1:0] nextLo;

   assign opSel    = op_e'(Op);
   assign accept   = Start && ((state == ST_IDLE) || (state == ST_DONE));
   assign lastStep = ((state == ST_MUL) || (state == ST_DIV)) && (count == LastCount);

   // State register; reset drops straight back to IDLE and so aborts any
   // operation in flight.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A request is only seen from IDLE or DONE, so a Start
   // during an iteration is simply dropped. Accepting from DONE chains the
   // next operation with no idle gap.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            nextState = ST_IDLE;
            if (Start) begin
               case (opSel)
                  OP_MULTU: nextState = ST_MUL;
                  OP_DIVU:  nextState = ST_DIV;
                  default:  nextState = ST_IDLE;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            if (lastStep) begin
               nextState = ST_DONE;
            end
         end
         default: nextState = ST_IDLE;
      endcase
   end

   // Status outputs are pure decodes of the state.
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state)
         ST_MUL, ST_DIV: Busy = 1'b1;
         ST_DONE:        Done = 1'b1;
         default: ;
      endcase
   end

   // The single shared adder. In MUL it adds the multiplicand into the upper
   // accumulator when the current multiplier bit is set. In DIV it subtracts
   // the divisor (add of the inverted value plus one) from the partial
   // remainder shifted left by one with the next dividend bit; the carry out
   // of that subtraction is the new quotient bit (1 means no borrow).
   always_comb begin
      addA    = {1'b0, accHi};
      addB    = '0;
      carryIn = 1'b0;
      if (state == ST_DIV) begin
         addA    = {accHi, accLo[WIDTH-1]};
         addB    = ~{1'b0, operandReg};
         carryIn = 1'b1;
      end else if (accLo[0]) begin
         addB = {1'b0, operandReg};
      end
      addSum = {1'b0, addA} + {1'b0, addB} + {{(WIDTH + 1){1'b0}}, carryIn};
   end

   // Next accumulator values for one iteration. Multiply shifts the
   // {upper, multiplier} pair right by one with the sum entering at the top.
   // Divide shifts the quotient bit into the low word and keeps either the
   // difference or, on a borrow, the shifted remainder (the restore step).
   // A zero divisor never borrows, which yields an all-ones quotient and a
   // remainder equal to the dividend with no extra logic.
   always_comb begin
      nextHi = accHi;
      nextLo = accLo;
      if (state == ST_MUL) begin
         nextHi = addSum[WIDTH:1];
         nextLo = {addSum[0], accLo[WIDTH-1:1]};
      end else if (state == ST_DIV) begin
         nextLo = {accLo[WIDTH-2:0], addSum[WIDTH+1]};
         nextHi = addSum[WIDTH+1] ? addSum[WIDTH-1:0] : addA[WIDTH-1:0];
      end
   end

   // Datapath registers. Operands are captured at acceptance so later changes
   // on the inputs are ignored. Hi/Lo are only written by the move
   // operations or on the final iteration, so partial results stay hidden.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         count      <= '0;
         operandReg <= '0;
         accHi      <= '0;
         accLo      <= '0;
         Hi         <= '0;
         Lo         <= '0;
         DivByZero  <= 1'b0;
      end else if (accept) begin
         count <= '0;
         if (isLongOp(opSel)) begin
            DivByZero <= 1'b0;
         end
         case (opSel)
            OP_MULTU: begin
               operandReg <= OperandA;
               accHi      <= '0;
               accLo      <= OperandB;
            end
            OP_DIVU: begin
               operandReg <= OperandB;
               accHi      <= '0;
               accLo      <= OperandA;
            end
            OP_MTHI: Hi <= OperandA;
            default: Lo <= OperandA;
         endcase
      end else if ((state == ST_MUL) || (state == ST_DIV)) begin
         count <= count + 1'b1;
         accHi <= nextHi;
         accLo <= nextLo;
         if (lastStep) begin
            Hi <= nextHi;
            Lo <= nextLo;
            if (state == ST_DIV) begin
               DivByZero <= (operandReg == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. Expected HI/LO/DivByZero values come
// from a plain-arithmetic model of the architectural registers; cycle
// timing expectations come from the WIDTH-cycle iteration rule.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   import mult_div_pkg::*;

   localparam int WIDTH = 32;

   logic             clk;
   logic             Reset;
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             Busy;
   logic             Done;
   logic             DivByZero;

   int vectors    = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] modelHi  = '0;
   logic [WIDTH-1:0] modelLo  = '0;
   logic             modelDbz = 1'b0;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .Hi        (Hi),
      .Lo        (Lo),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural reference: what HI/LO/DivByZero hold once op completes.
   function automatic void computeModel(input op_e op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        output logic [WIDTH-1:0] expHi,
                                        output logic [WIDTH-1:0] expLo,
                                        output logic expDbz);
      logic [2*WIDTH-1:0] product;
      expHi  = modelHi;
      expLo  = modelLo;
      expDbz = modelDbz;
      case (op)
         OP_MULTU: begin
            product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            expHi   = product[2*WIDTH-1:WIDTH];
            expLo   = product[WIDTH-1:0];
            expDbz  = 1'b0;
         end
         OP_DIVU: begin
            if (b == '0) begin
               expLo  = '1;
               expHi  = a;
               expDbz = 1'b1;
            end else begin
               expLo  = a / b;
               expHi  = a % b;
               expDbz = 1'b0;
            end
         end
         OP_MTHI: expHi = a;
         default: expLo = a;
      endcase
   endfunction

   // Presents a request for one cycle, then scrambles the operand inputs so
   // any dependence on them after acceptance shows up in the result.
   task automatic applyStimulus(input op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(negedge clk);
      Start    = 1'b0;
      OperandA = $urandom;
      OperandB = $urandom;
   endtask

   // n busy cycles: Busy high, Done low, HI/LO still at their old values.
   task automatic checkBusyPhase(input int n);
      for (int i = 0; i < n; i++) begin
         checkOutput("busy_high", 64'(Busy), 64'd1);
         checkOutput("done_low_busy", 64'(Done), 64'd0);
         checkOutput("hi_hold", 64'(Hi), 64'(modelHi));
         checkOutput("lo_hold", 64'(Lo), 64'(modelLo));
         checkOutput("dbz_cleared", 64'(DivByZero), 64'd0);
         @(negedge clk);
      end
   endtask

   // The DONE cycle: pulse present and final results visible.
   task automatic completeOp(input op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] expHi;
      logic [WIDTH-1:0] expLo;
      logic             expDbz;
      computeModel(op, a, b, expHi, expLo, expDbz);
      modelHi  = expHi;
      modelLo  = expLo;
      modelDbz = expDbz;
      checkOutput("done_pulse", 64'(Done), 64'd1);
      checkOutput("busy_low_done", 64'(Busy), 64'd0);
      checkOutput("hi_result", 64'(Hi), 64'(modelHi));
      checkOutput("lo_result", 64'(Lo), 64'(modelLo));
      checkOutput("dbz_result", 64'(DivByZero), 64'(modelDbz));
   endtask

   // A complete operation from an idle unit, including the return to IDLE.
   task automatic runOp(input op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] expHi;
      logic [WIDTH-1:0] expLo;
      logic             expDbz;
      applyStimulus(op, a, b);
      if (isLongOp(op)) begin
         checkBusyPhase(WIDTH);
         completeOp(op, a, b);
         @(negedge clk);
         checkOutput("done_one_cycle", 64'(Done), 64'd0);
         checkOutput("idle_not_busy", 64'(Busy), 64'd0);
      end else begin
         computeModel(op, a, b, expHi, expLo, expDbz);
         modelHi  = expHi;
         modelLo  = expLo;
         modelDbz = expDbz;
         checkOutput("move_busy_low", 64'(Busy), 64'd0);
         checkOutput("move_done_low", 64'(Done), 64'd0);
         checkOutput("move_hi", 64'(Hi), 64'(modelHi));
         checkOutput("move_lo", 64'(Lo), 64'(modelLo));
         checkOutput("move_dbz", 64'(DivByZero), 64'(modelDbz));
      end
   endtask

   // Directed scenarios followed by a randomized run, all in one sequence.
   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      op_e              rop;

      Reset    = 1'b1;
      Start    = 1'b0;
      Op       = 2'b00;
      OperandA = '0;
      OperandB = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_hi", 64'(Hi), 64'd0);
      checkOutput("reset_lo", 64'(Lo), 64'd0);
      checkOutput("reset_busy", 64'(Busy), 64'd0);
      checkOutput("reset_done", 64'(Done), 64'd0);
      checkOutput("reset_dbz", 64'(DivByZero), 64'd0);
      Reset = 1'b0;
      @(negedge clk);

      runOp(OP_MULTU, 32'd7, 32'd6);
      checkOutput("mul7x6_lo", 64'(Lo), 64'd42);
      checkOutput("mul7x6_hi", 64'(Hi), 64'd0);

      runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("mulmax_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFE);
      checkOutput("mulmax_lo", 64'(Lo), 64'h0000_0000_0000_0001);

      runOp(OP_DIVU, 32'd100, 32'd7);
      checkOutput("div100_7_lo", 64'(Lo), 64'd14);
      checkOutput("div100_7_hi", 64'(Hi), 64'd2);
      runOp(OP_DIVU, 32'd5, 32'd0);
      checkOutput("div5_0_lo", 64'(Lo), 64'h0000_0000_FFFF_FFFF);
      checkOutput("div5_0_hi", 64'(Hi), 64'd5);
      checkOutput("div5_0_dbz", 64'(DivByZero), 64'd1);

      runOp(OP_MTHI, 32'h1234_5678, 32'd0);
      runOp(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
      checkOutput("mthi_val", 64'(Hi), 64'h0000_0000_1234_5678);
      checkOutput("mtlo_val", 64'(Lo), 64'h0000_0000_9ABC_DEF0);
      checkOutput("move_keeps_dbz", 64'(DivByZero), 64'd1);

      for (int n = 0; n < 20; n++) begin
         rop = op_e'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 4) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
         runOp(rop, ra, rb);
      end

      // A Start in the middle of a divide is dropped; a Start in the DONE
      // cycle chains straight into the next operation.
      applyStimulus(OP_DIVU, 32'd9, 32'd2);
      checkBusyPhase(4);
      Start    = 1'b1;
      Op       = OP_MULTU;
      OperandA = 32'd3;
      OperandB = 32'd3;
      checkBusyPhase(1);
      Start = 1'b0;
      checkBusyPhase(WIDTH - 5);
      completeOp(OP_DIVU, 32'd9, 32'd2);
      checkOutput("div9_2_lo", 64'(Lo), 64'd4);
      checkOutput("div9_2_hi", 64'(Hi), 64'd1);
      applyStimulus(OP_MULTU, 32'd3, 32'd3);
      checkBusyPhase(WIDTH);
      completeOp(OP_MULTU, 32'd3, 32'd3);
      checkOutput("chained_lo", 64'(Lo), 64'd9);
      @(negedge clk);
      checkOutput("chained_idle", 64'(Busy), 64'd0);

      // Leave the flag set, then abort a multiply with reset.
      runOp(OP_DIVU, $urandom, 32'd0);
      applyStimulus(OP_MULTU, 32'd2, 32'd2);
      checkBusyPhase(9);
      Reset = 1'b1;
      #1;
      modelHi  = '0;
      modelLo  = '0;
      modelDbz = 1'b0;
      checkOutput("abort_hi", 64'(Hi), 64'd0);
      checkOutput("abort_lo", 64'(Lo), 64'd0);
      checkOutput("abort_busy", 64'(Busy), 64'd0);
      checkOutput("abort_done", 64'(Done), 64'd0);
      checkOutput("abort_dbz", 64'(DivByZero), 64'd0);
      @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_stays_idle", 64'(Busy), 64'd0);
      runOp(OP_MULTU, 32'd2, 32'd2);
      checkOutput("after_abort_lo", 64'(Lo), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 32, operand/result width; the iteration count equals WIDTH.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request pulse; sampled only when Busy=0.
- Op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- OperandA  input  WIDTH  multiplicand, dividend, or move data; driven from register-file ReadData1.
- OperandB  input  WIDTH  multiplier or divisor; driven from register-file ReadData2.
- Hi  output  WIDTH  HI register: product upper half, or remainder.
- Lo  output  WIDTH  LO register: product lower half, or quotient.
- Busy  output  1  iteration in progress.
- Done  output  1  one-cycle completion pulse for MULTU and DIVU.
- DivByZero  output  1  the last DIVU had OperandB=0.

Function
REQ-004 The FSM SHALL have states IDLE, MUL, DIV and DONE; Busy SHALL be 1 exactly in MUL and DIV, and Done SHALL be 1 exactly in DONE.
REQ-005 Start=1 with Busy=0 (IDLE or DONE) at edge E0 SHALL be accepted: OperandA/OperandB latched internally, iteration counter cleared, and the next state set from Op.
REQ-006 For MULTU, the block SHALL perform unsigned shift-add multiply, one partial product per cycle, for WIDTH cycles in MUL.
REQ-007 For DIVU, the block SHALL perform unsigned restoring divide, one quotient bit per cycle, for WIDTH cycles in DIV.
REQ-008 At edge E_WIDTH, MULTU/DIVU SHALL write Hi/Lo and enter DONE; Done SHALL be high in the cycle after E_WIDTH; the next edge SHALL go to IDLE unless a new Start is accepted.
REQ-009 MULTU results SHALL be the full 2*WIDTH-bit unsigned product {Hi,Lo}, with no truncation.
REQ-010 DIVU results SHALL be Lo = quotient and Hi = remainder.
REQ-011 MTHI/MTLO SHALL write OperandA into Hi or Lo at edge E0, stay in or return to IDLE, and leave Done low.
REQ-012 Hi and Lo SHALL hold their previous values throughout MUL/DIV; partial results SHALL never be visible.
REQ-013 Start while Busy=1 SHALL be ignored: no latch, no state change, no queuing.
REQ-014 Changes to OperandA/OperandB after E0 SHALL not affect the result.
REQ-015 Divide by zero SHALL still take WIDTH cycles and produce Lo = all ones and Hi = OperandA; DivByZero SHALL be set at E_WIDTH.
REQ-016 DivByZero SHALL clear on the next accepted MULTU/DIVU Start and SHALL be unaffected by MTHI/MTLO.
REQ-017 Start accepted in DONE SHALL begin the new operation at that edge, so Done and the new Busy appear back to back.

Reset
REQ-018 Reset=1 SHALL, asynchronously: set the state to IDLE, clear Hi, Lo, the counter and the internal accumulators to 0, and drive Busy=0, Done=0, DivByZero=0.
REQ-019 Reset asserted mid-operation SHALL abort the operation with no Hi/Lo write; the first Start after deassertion SHALL be accepted normally.

Structure
REQ-020 The Op encodings and the state encoding SHALL reside in shared package mult_div_pkg, for reuse by the control unit.
REQ-021 The block SHALL be a single module with no sub-module; one shared WIDTH+1-bit adder/subtractor SHALL serve both MUL and DIV.

Verification
REQ-022 MULTU 7 x 6 at E0 -> Busy high 32 cycles, Done pulse one cycle after E32, Hi=0, Lo=42.
REQ-023 MULTU FFFFFFFF x FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; Hi/Lo unchanged until E32.
REQ-024 DIVU 100 / 7 -> Lo=14, Hi=2, DivByZero=0; then DIVU 5 / 0 -> Lo=FFFFFFFF, Hi=5, DivByZero=1.
REQ-025 MTHI 12345678 then MTLO 9ABCDEF0 on consecutive cycles -> Hi=12345678, Lo=9ABCDEF0, Done never high, Busy never high.
REQ-026 Start MULTU 3 x 3 at cycle 5 of a running DIVU 9 / 2 -> ignored; final Lo=4, Hi=1. Then Start issued in the DONE cycle -> accepted with no gap.
REQ-027 Reset pulse at cycle 10 of MULTU 2 x 2 -> Hi=Lo=0, IDLE, Busy=0; a following MULTU 2 x 2 gives Lo=4.
